// File: rtl/lsu_mem_port.sv
// Load/store unit front end driving a word-addressed data-memory bus.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_mem_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  Stall,
  output logic                  bus_err,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [CW-1:0] cnt;
  logic          req;
  logic          f3_ok;
  logic          mis;
  logic [31:0]   sh;
  logic [31:0]   ld_val;

  assign req = MemRead | MemWrite;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~MemWrite;
      default:                f3_ok = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Only legal half/word codes can be misaligned; 101 is not a store size.
  always_comb begin
    mis = 1'b0;
    case (funct3)
      3'b001:  mis = addr[0];
      3'b101:  mis = addr[0] & ~MemWrite;
      3'b010:  mis = |addr[1:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    sh     = mem_rdata >> {off_q, 3'b000};
    ld_val = mem_rdata;
    case (f3_q)
      3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_val = {24'h0, sh[7:0]};
      3'b101:  ld_val = {16'h0, sh[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    case (state)
      IDLE:    Stall = req;
      ACCESS:  Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      off_q     <= '0;
      f3_q      <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: if (req) begin
          off_q    <= addr[1:0];
          f3_q     <= funct3;
          cnt      <= '0;
          mem_we   <= MemWrite;
          mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be    <= 4'b1111;
          mem_wdata <= wdata;
          if (MemWrite) begin
            case (funct3[1:0])
              2'b00: begin
                mem_be    <= 4'b0001 << addr[1:0];
                mem_wdata <= {4{wdata[7:0]}};
              end
              2'b01: begin
                mem_be    <= 4'b0011 << addr[1:0];
                mem_wdata <= {2{wdata[15:0]}};
              end
              default: ;
            endcase
          end
          if (mis) begin
            state    <= DONE;
            rdata    <= '0;
            misalign <= 1'b1;
          end else if (!f3_ok) begin
            state   <= DONE;
            rdata   <= '0;
            bus_err <= 1'b1;
          end else begin
            state   <= ACCESS;
            mem_req <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we) rdata <= ld_val;
          end else if (cnt == LAST) begin
            state   <= DONE;
            mem_req <= 1'b0;
            rdata   <= '0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed steps plus random accesses
// checked against an arithmetic model of the access rules.
module tb_lsu_mem_port;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite, MemRead;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        Stall, bus_err, misalign;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .Stall(Stall), .bus_err(bus_err), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(bit st, logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5;
  endfunction

  function automatic int m_nb(logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_mis(bit st, logic [2:0] f3, logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int nb = m_nb(f3);
    if (!m_legal(st, f3)) return 1'b0;
    return (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(bit st, logic [2:0] f3, int off);
    int nb = m_nb(f3);
    if (!st || nb == 4) return 4'hF;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] wd);
    int nb = m_nb(f3);
    if (nb == 1) return (wd % 256) * 32'h01010101;
    if (nb == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(logic [2:0] f3, int off,
                                       logic [31:0] w);
    int nb = m_nb(f3);
    longint v, rng;
    if (nb == 4) return w;
    rng = longint'(1) << (8 * nb);
    v = (longint'(w) >> (8 * off)) % rng;
    if (f3 < 4 && v >= rng / 2) v = v - rng;
    return 32'(v);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit we, input bit rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] word);
    bit st = we;
    int off = a % 4;
    bit mis = m_mis(st, f3, a);
    bit ok = m_legal(st, f3);
    bit tmo = 1'b0;
    MemWrite = we; MemRead = rd; funct3 = f3;
    addr = a; wdata = wd; mem_ready = 1'b0;
    @(negedge clk);
    chk("stall_idle", 32'(Stall), 32'(rd | we));
    step();
    if (mis || !ok) begin
      @(negedge clk);
      chk("err_req", 32'(mem_req), 0);
      chk("err_stall", 32'(Stall), 0);
      chk("err_bus_err", 32'(bus_err), 32'(!mis));
      chk("err_misalign", 32'(misalign), 32'(mis));
      exp_rd = 32'h0;
      chk("err_rdata", rdata, exp_rd);
    end else begin
      for (int k = 0; ; k++) begin
        mem_ready = (k == waits);
        mem_rdata = (k == waits) ? word : $urandom;
        @(negedge clk);
        chk("acc_req", 32'(mem_req), 1);
        chk("acc_stall", 32'(Stall), 1);
        chk("acc_we", 32'(mem_we), 32'(st));
        chk("acc_addr", mem_addr, a & ~32'h3);
        chk("acc_be", 32'(mem_be), 32'(m_be(st, f3, off)));
        if (st) chk("acc_wdata", mem_wdata, m_wd(f3, wd));
        step();
        if (k == waits) break;
        if (k == T - 1) begin
          tmo = 1'b1;
          break;
        end
      end
      mem_ready = 1'b0;
      if (tmo) exp_rd = 32'h0;
      else if (!st) exp_rd = m_rd(f3, off, word);
      @(negedge clk);
      chk("done_req", 32'(mem_req), 0);
      chk("done_stall", 32'(Stall), 0);
      chk("done_bus_err", 32'(bus_err), 32'(tmo));
      chk("done_misalign", 32'(misalign), 0);
      chk("done_rdata", rdata, exp_rd);
    end
    step();
    MemWrite = 1'b0; MemRead = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(mem_req), 0);
    chk("idle_bus_err", 32'(bus_err), 0);
    chk("idle_misalign", 32'(misalign), 0);
    chk("idle_rdata", rdata, exp_rd);
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_stall", 32'(Stall), 0);
    step();
    rst = 1'b0;
    step();

    access(1, 0, 3'b000, 32'h103, 32'h000000AB, 0, 32'h0);
    access(0, 1, 3'b000, 32'h102, 32'h0, 0, 32'h0080FF11);
    access(0, 1, 3'b100, 32'h102, 32'h0, 1, 32'h0080FF11);
    access(0, 1, 3'b001, 32'h202, 32'h0, 3, 32'h80011234);
    access(0, 1, 3'b010, 32'h300, 32'h0, 100, 32'h0);
    access(0, 1, 3'b011, 32'h300, 32'h0, 0, 32'h0);
    access(1, 0, 3'b101, 32'h300, 32'h1234, 0, 32'h0);
    access(1, 1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 32'h0);
    access(1, 0, 3'b001, 32'h3, 32'hCAFE1234, 2, 32'h0);
    access(0, 1, 3'b101, 32'h3, 32'h0, 0, 32'h8899AABB);
    access(0, 1, 3'b010, 32'h41, 32'h0, 0, 32'h13579BDF);

    // Abort a store mid-access with reset; no completion may follow
    MemWrite = 1'b1; MemRead = 1'b1; funct3 = 3'b010;
    addr = 32'h40; wdata = 32'hDEADBEEF; mem_ready = 1'b0;
    step();
    @(negedge clk);
    chk("rst_acc_req1", 32'(mem_req), 1);
    chk("rst_acc_we", 32'(mem_we), 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc_req2", 32'(mem_req), 1);
    step();
    rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk("rst_acc_drop", 32'(mem_req), 0);
    chk("rst_acc_err", 32'(bus_err), 0);
    chk("rst_acc_rdata", rdata, 0);
    exp_rd = 32'h0;
    step();
    @(negedge clk);
    chk("rst_acc_idle", 32'(mem_req), 0);
    chk("rst_acc_nodone", 32'(bus_err), 0);
    step();

    for (int i = 0; i < 60; i++) begin
      bit we = 1'($urandom_range(0, 1));
      bit rd = we ? 1'($urandom_range(0, 1)) : 1'b1;
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
           3'($urandom_range(0, 2) + (!we && $urandom_range(0, 1) ? 4 : 0));
      access(we, rd, f3, $urandom, $urandom, $urandom_range(0, 5), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
